psg_bus_interface: RTL and testbench

Upstream register stage for the SN76489-compatible PSG. It accepts host byte writes in SN76489 latch/data format through an active-low write strobe. It holds the channel register file: three 10-bit tone periods, four 4-bit attenuations and a 3-bit noise control. It drives the tone generators, the noise control decoder and the noise generator's LFSR reset, and emulates the chip's READY handshake.

---
 rtl/psg_bus_interface.sv | 153 +++++++++++++++
 tb/tb_psg_bus_interface.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/psg_bus_interface.sv
// SN76489-style host register stage: latch/data byte decode, channel register file, READY emulation.
// Optional READY handshake is enabled by defining PSG_READY_EN.
//
// state  | meaning
// S_IDLE | ready high, next falling strobe is accepted
// S_BUSY | ready low, down-counter running, strobes dropped
module psg_bus_interface #(
  parameter int COUNTER_BITS     = 10,
  parameter int ATTENUATION_BITS = 4,
  parameter int READY_CYCLES     = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [7:0]                  data_i,
  input  logic                        we_n_i,
  output logic                        ready_o,
  output logic [COUNTER_BITS-1:0]     tone_freq0_o,
  output logic [COUNTER_BITS-1:0]     tone_freq1_o,
  output logic [COUNTER_BITS-1:0]     tone_freq2_o,
  output logic [ATTENUATION_BITS-1:0] attenuation0_o,
  output logic [ATTENUATION_BITS-1:0] attenuation1_o,
  output logic [ATTENUATION_BITS-1:0] attenuation2_o,
  output logic [ATTENUATION_BITS-1:0] attenuation3_o,
  output logic [2:0]                  noise_control_o,
  output logic                        noise_reset_o
);

  if (READY_CYCLES < 1 || READY_CYCLES > 255) begin : g_bad_ready_cycles
    $error("psg_bus_interface: READY_CYCLES must be in 1..255");
  end

  logic                        we_n_d_q;
  logic                        ready;
  logic                        accept;
  logic [1:0]                  latch_ch_q, latch_ch_d;
  logic                        latch_type_q, latch_type_d;
  logic [COUNTER_BITS-1:0]     tone_q [3];
  logic [COUNTER_BITS-1:0]     tone_d [3];
  logic [ATTENUATION_BITS-1:0] atten_q [4];
  logic [ATTENUATION_BITS-1:0] atten_d [4];
  logic [2:0]                  noise_q, noise_d;
  logic                        noise_reset_q, noise_reset_d;

  assign accept = !we_n_i && we_n_d_q && ready;

  // The edge detector keeps sampling through reset so a strobe already low at release is not a new edge.
  always_ff @(posedge clk_i) begin
    we_n_d_q <= we_n_i;
  end

  always_comb begin
    latch_ch_d    = latch_ch_q;
    latch_type_d  = latch_type_q;
    tone_d        = tone_q;
    atten_d       = atten_q;
    noise_d       = noise_q;
    noise_reset_d = 1'b0;
    if (accept) begin
      if (data_i[7]) begin
        latch_ch_d   = data_i[6:5];
        latch_type_d = data_i[4];
        if (data_i[4]) begin
          atten_d[data_i[6:5]] = data_i[ATTENUATION_BITS-1:0];
        end else if (data_i[6:5] == 2'd3) begin
          noise_d       = data_i[2:0];
          noise_reset_d = 1'b1;
        end else begin
          tone_d[data_i[6:5]][3:0] = data_i[3:0];
        end
      end else begin
        if (latch_type_q) begin
          atten_d[latch_ch_q] = data_i[ATTENUATION_BITS-1:0];
        end else if (latch_ch_q == 2'd3) begin
          noise_d       = data_i[2:0];
          noise_reset_d = 1'b1;
        end else begin
          tone_d[latch_ch_q][COUNTER_BITS-1:4] = data_i[COUNTER_BITS-5:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      latch_ch_q    <= 2'd0;
      latch_type_q  <= 1'b0;
      noise_q       <= 3'd0;
      noise_reset_q <= 1'b0;
      for (int i = 0; i < 3; i++) tone_q[i] <= '0;
      for (int i = 0; i < 4; i++) atten_q[i] <= '1;
    end else begin
      latch_ch_q    <= latch_ch_d;
      latch_type_q  <= latch_type_d;
      noise_q       <= noise_d;
      noise_reset_q <= noise_reset_d;
      tone_q        <= tone_d;
      atten_q       <= atten_d;
    end
  end

`ifdef PSG_READY_EN
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [7:0] READY_LOAD = 8'(READY_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = READY_LOAD;
        end
      end
      S_BUSY: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready = (state_q == S_IDLE);
`else
  assign ready = 1'b1;
`endif

  assign ready_o         = ready;
  assign tone_freq0_o    = tone_q[0];
  assign tone_freq1_o    = tone_q[1];
  assign tone_freq2_o    = tone_q[2];
  assign attenuation0_o  = atten_q[0];
  assign attenuation1_o  = atten_q[1];
  assign attenuation2_o  = atten_q[2];
  assign attenuation3_o  = atten_q[3];
  assign noise_control_o = noise_q;
  assign noise_reset_o   = noise_reset_q;

endmodule

// File: tb/tb_psg_bus_interface.sv
// Directed scoreboard bench for psg_bus_interface; READY checks follow the PSG_READY_EN build.
module tb_psg_bus_interface;
  localparam int RC = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       we_n;
  logic [7:0] data;
  logic       ready_o;
  logic [9:0] tone_freq0_o, tone_freq1_o, tone_freq2_o;
  logic [3:0] attenuation0_o, attenuation1_o, attenuation2_o, attenuation3_o;
  logic [2:0] noise_control_o;
  logic       noise_reset_o;

  psg_bus_interface #(.COUNTER_BITS(10), .ATTENUATION_BITS(4), .READY_CYCLES(RC)) dut (
    .clk_i(clk), .reset_i(reset), .data_i(data), .we_n_i(we_n), .ready_o(ready_o),
    .tone_freq0_o(tone_freq0_o), .tone_freq1_o(tone_freq1_o), .tone_freq2_o(tone_freq2_o),
    .attenuation0_o(attenuation0_o), .attenuation1_o(attenuation1_o),
    .attenuation2_o(attenuation2_o), .attenuation3_o(attenuation3_o),
    .noise_control_o(noise_control_o), .noise_reset_o(noise_reset_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] t0, t1, t2;
    logic [3:0] a0, a1, a2, a3;
    logic [2:0] nc;
    logic       nr;
  } exp_t;

  exp_t       sb_q[$];
  logic [9:0] m_tone [3];
  logic [3:0] m_att [4];
  logic [2:0] m_nc;
  logic [1:0] m_ch;
  logic       m_type;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = 10'h000;
    for (int i = 0; i < 4; i++) m_att[i] = 4'hF;
    m_nc = 3'd0; m_ch = 2'd0; m_type = 1'b0;
  endfunction

  // Reference behaviour of one accepted byte; returns whether noise_reset must pulse.
  function automatic logic model_write(input logic [7:0] b);
    logic nr;
    nr = 1'b0;
    if (b[7]) begin
      m_ch = b[6:5]; m_type = b[4];
    end
    if (m_type) m_att[m_ch] = b[3:0];
    else if (m_ch == 2'd3) begin
      m_nc = b[2:0]; nr = 1'b1;
    end else if (b[7]) m_tone[m_ch][3:0] = b[3:0];
    else m_tone[m_ch][9:4] = b[5:0];
    return nr;
  endfunction

  function automatic exp_t snap(input logic nr);
    exp_t e;
    e.t0 = m_tone[0]; e.t1 = m_tone[1]; e.t2 = m_tone[2];
    e.a0 = m_att[0]; e.a1 = m_att[1]; e.a2 = m_att[2]; e.a3 = m_att[3];
    e.nc = m_nc; e.nr = nr;
    return e;
  endfunction

  task automatic check_pop(input string tag);
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, ".t0"}, 32'(tone_freq0_o), 32'(e.t0));
      chk({tag, ".t1"}, 32'(tone_freq1_o), 32'(e.t1));
      chk({tag, ".t2"}, 32'(tone_freq2_o), 32'(e.t2));
      chk({tag, ".a0"}, 32'(attenuation0_o), 32'(e.a0));
      chk({tag, ".a1"}, 32'(attenuation1_o), 32'(e.a1));
      chk({tag, ".a2"}, 32'(attenuation2_o), 32'(e.a2));
      chk({tag, ".a3"}, 32'(attenuation3_o), 32'(e.a3));
      chk({tag, ".nc"}, 32'(noise_control_o), 32'(e.nc));
      chk({tag, ".nr"}, 32'(noise_reset_o), 32'(e.nr));
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".ready_timeout"}, 32'(ready_o), 32'd1);
  endtask

  task automatic wr(input logic [7:0] b, input string tag);
    logic nr;
    @(negedge clk);
    data = b; we_n = 1'b0;
    nr = model_write(b);
    sb_q.push_back(snap(nr));
    @(posedge clk); #1;
    check_pop(tag);
`ifdef PSG_READY_EN
    chk({tag, ".ready_low"}, 32'(ready_o), 32'd0);
`else
    chk({tag, ".ready"}, 32'(ready_o), 32'd1);
`endif
    @(negedge clk);
    we_n = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".nr_drop"}, 32'(noise_reset_o), 32'd0);
`ifdef PSG_READY_EN
    wait_ready(tag);
`endif
  endtask

  initial begin
    int low_cnt;
    int n;
    logic nr;
    reset = 1'b1; we_n = 1'b1; data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(snap(1'b0));
    @(posedge clk); #1;
    check_pop("reset");
    chk("reset.ready", 32'(ready_o), 32'd1);

    wr(8'hAE, "tone1_lo");
    wr(8'h3F, "tone1_hi");
    wr(8'hD5, "att2_latch");
    wr(8'h07, "att2_data");
    wr(8'hC8, "tone2_lo");
    wr(8'h55, "tone2_hi_b6");

    // Noise latch with the strobe held low: exactly one pulse, no retrigger.
    @(negedge clk);
    data = 8'hE6; we_n = 1'b0;
    nr = model_write(8'hE6);
    sb_q.push_back(snap(nr));
    @(posedge clk); #1;
    check_pop("noise_latch");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("noise_hold.nr", 32'(noise_reset_o), 32'd0);
      chk("noise_hold.nc", 32'(noise_control_o), 32'(m_nc));
    end
    @(negedge clk);
    we_n = 1'b1;
`ifdef PSG_READY_EN
    wait_ready("noise_latch");
`endif
    wr(8'h01, "noise_data");

`ifdef PSG_READY_EN
    // READY window length, dropped strobe during BUSY, then earliest accept.
    @(negedge clk);
    data = 8'h9A; we_n = 1'b0;
    nr = model_write(8'h9A);
    sb_q.push_back(snap(nr));
    @(posedge clk); #1;
    check_pop("busy_accept");
    sb_q.push_back(snap(1'b0));
    low_cnt = 0; n = 0;
    while (ready_o === 1'b0 && n < 300) begin
      low_cnt++;
      @(negedge clk);
      if (low_cnt == 1) we_n = 1'b1;
      if (low_cnt == 10) begin data = 8'h85; we_n = 1'b0; end
      if (low_cnt == 12) we_n = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("busy.low_cycles", 32'(low_cnt), 32'(RC));
    check_pop("busy_drop");
    wr(8'h83, "after_busy");
`else
    wr(8'h9A, "att0_latch");
    wr(8'h83, "tone0_lo");
`endif

    // Reset while the previous write is still in progress, strobe low across release.
    @(negedge clk);
    data = 8'h12; we_n = 1'b0;
    nr = model_write(8'h12);
    sb_q.push_back(snap(nr));
    @(posedge clk); #1;
    check_pop("tone0_hi");
    @(negedge clk);
    we_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; we_n = 1'b0; data = 8'h90;
    model_reset();
    sb_q.push_back(snap(1'b0));
    @(posedge clk); #1;
    check_pop("rst_busy");
    chk("rst_busy.ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(snap(1'b0));
    repeat (3) @(posedge clk);
    #1;
    check_pop("rst_release_low");
    chk("rst_release.ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    we_n = 1'b1;
    wr(8'h8C, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
